// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and widths for the I2C bus arbiter
// Purpose: arbiter FSM state encoding, field widths and the per-requester
//          transaction descriptor used by i2c_bus_arbiter and its picker.
// Ports:   none (package).
package i2c_arb_pkg;

    localparam int ADR_W   = 7;
    localparam int DATA_W  = 32;
    localparam int BYTES_W = 3;
    localparam int CH_W    = 4;
    localparam int GID_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_WR = 3'd1,
        S_WAIT_WR  = 3'd2,
        S_ISSUE_RD = 3'd3,
        S_WAIT_RD  = 3'd4,
        S_RELEASE  = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic [ADR_W-1:0]   adr;
        logic [DATA_W-1:0]  wr_data;
        logic [BYTES_W-1:0] wr_bytes;
        logic [BYTES_W-1:0] rd_bytes;
        logic [CH_W-1:0]    rd_channels;
    } arb_desc_t;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// rtl/i2c_arb_rr_pick.sv - combinational round-robin picker
// Purpose: returns the first pending requester strictly after the pointer,
//          wrapping around, so the last owner has lowest priority.
// Ports:   i_pending  pending mask
//          i_ptr      index of the previous owner
//          o_idx      selected requester index
//          o_vld      at least one requester pending
module i2c_arb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    // Rotate the mask so bit 0 is the requester just after the pointer.
    always_comb begin
        w_dbl = {i_pending, i_pending} >> (int'(i_ptr) + 1);
        w_rot = w_dbl[N_REQ-1:0];
    end

    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_vld && w_rot[k]) begin
                o_vld = 1'b1;
                o_idx = IDX_W'((int'(i_ptr) + 1 + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one I2C master core
// Purpose: latches per-requester command pulses and descriptors into slots,
//          grants the master round-robin, replays write then read phases and
//          routes completion / read strobes back to the owner.
// Optional: I2C_ARB_TIMEOUT_EN enables a WAIT-state watchdog (TIMEOUT_CYC).
// Ports:   clk, reset                         clock, sync active-high reset
//          req_wr_flg/req_rd_flg              per-requester command pulses
//          req_adr/wr_data/wr_bytes/rd_bytes/rd_channels  packed descriptors
//          req_busy/req_done/req_err/req_rd_data_en       per-requester status
//          grant_id, grant_vld                current owner
//          m_wr_flg/m_rd_flg/m_adr/m_wr_data/m_wr_bytes/m_rd_bytes/m_rd_channels
//                                             command to the master core
//          m_rd_data_en, m_done               master status
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_wr_flg,
    input  logic [N_REQ-1:0]         req_rd_flg,
    input  logic [ADR_W*N_REQ-1:0]   req_adr,
    input  logic [DATA_W*N_REQ-1:0]  req_wr_data,
    input  logic [BYTES_W*N_REQ-1:0] req_wr_bytes,
    input  logic [BYTES_W*N_REQ-1:0] req_rd_bytes,
    input  logic [CH_W*N_REQ-1:0]    req_rd_channels,
    output logic [N_REQ-1:0]         req_busy,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_err,
    output logic [N_REQ-1:0]         req_rd_data_en,
    output logic [GID_W-1:0]         grant_id,
    output logic                     grant_vld,
    output logic                     m_wr_flg,
    output logic                     m_rd_flg,
    output logic [ADR_W-1:0]         m_adr,
    output logic [DATA_W-1:0]        m_wr_data,
    output logic [BYTES_W-1:0]       m_wr_bytes,
    output logic [BYTES_W-1:0]       m_rd_bytes,
    output logic [CH_W-1:0]          m_rd_channels,
    input  logic                     m_rd_data_en,
    input  logic                     m_done
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       r_state, w_next_state;
    arb_desc_t        w_req_desc  [N_REQ];
    arb_desc_t        r_slot_desc [N_REQ];
    logic [N_REQ-1:0] r_slot_vld, r_slot_wr, r_slot_rd;
    logic [N_REQ-1:0] r_req_err;
    logic [N_REQ-1:0] w_owner_oh;
    logic [SEL_W-1:0] r_rr_ptr, r_grant_id, w_pick_idx;
    logic             w_pick_vld;
    logic             r_grant_vld;
    logic             r_abort;
    arb_desc_t        r_m_desc;
    logic             w_timeout;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_req_desc[i].adr         = req_adr[ADR_W*i +: ADR_W];
            w_req_desc[i].wr_data     = req_wr_data[DATA_W*i +: DATA_W];
            w_req_desc[i].wr_bytes    = req_wr_bytes[BYTES_W*i +: BYTES_W];
            w_req_desc[i].rd_bytes    = req_rd_bytes[BYTES_W*i +: BYTES_W];
            w_req_desc[i].rd_channels = req_rd_channels[CH_W*i +: CH_W];
        end
    end

    i2c_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (SEL_W)
    ) u_pick (
        .i_pending (r_slot_vld),
        .i_ptr     (r_rr_ptr),
        .o_idx     (w_pick_idx),
        .o_vld     (w_pick_vld)
    );

    assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // Slot capture. The owner's slot stays full until RELEASE ends, so a
    // pulse during service or in the RELEASE cycle itself is rejected.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_vld <= '0;
            r_slot_wr  <= '0;
            r_slot_rd  <= '0;
            r_req_err  <= '0;
        end else begin
            r_req_err <= w_timeout ? w_owner_oh : '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_wr_flg[i] || req_rd_flg[i]) begin
                    if (r_slot_vld[i]) begin
                        r_req_err[i] <= 1'b1;
                    end else begin
                        r_slot_vld[i]  <= 1'b1;
                        r_slot_wr[i]   <= req_wr_flg[i];
                        r_slot_rd[i]   <= req_rd_flg[i];
                        r_slot_desc[i] <= w_req_desc[i];
                    end
                end
            end
            if (r_state == S_RELEASE) begin
                r_slot_vld[r_grant_id] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_wr_flg     = 1'b0;
        m_rd_flg     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_next_state = r_slot_wr[w_pick_idx] ? S_ISSUE_WR : S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: begin
                m_wr_flg     = 1'b1;
                w_next_state = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (w_timeout) begin
                    w_next_state = S_RELEASE;
                end else if (m_done) begin
                    w_next_state = r_slot_rd[r_grant_id] ? S_ISSUE_RD : S_RELEASE;
                end
            end
            S_ISSUE_RD: begin
                m_rd_flg     = 1'b1;
                w_next_state = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (w_timeout || m_done) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Grant and master fields are loaded once at grant time; the slot cannot
    // change while owned, so this matches driving them from the slot in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_rr_ptr    <= SEL_W'(N_REQ - 1);
            r_m_desc    <= '0;
            r_abort     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_pick_vld) begin
                r_grant_vld <= 1'b1;
                r_grant_id  <= w_pick_idx;
                r_m_desc    <= r_slot_desc[w_pick_idx];
                r_abort     <= 1'b0;
            end
            if (w_timeout) begin
                r_abort <= 1'b1;
            end
            if (r_state == S_RELEASE) begin
                r_grant_vld <= 1'b0;
                r_rr_ptr    <= r_grant_id;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        w_in_wait;

    assign w_in_wait = (r_state == S_WAIT_WR) || (r_state == S_WAIT_RD);

    always_ff @(posedge clk) begin
        if (reset || !w_in_wait || (w_next_state != r_state)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    // A completion arriving on the last allowed cycle still wins.
    assign w_timeout = w_in_wait && !m_done && (r_wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
`endif

    assign req_busy       = r_slot_vld;
    assign req_err        = r_req_err;
    assign req_done       = (r_state == S_RELEASE && !r_abort) ? w_owner_oh : '0;
    assign req_rd_data_en = {N_REQ{m_rd_data_en & r_grant_vld}} & w_owner_oh;
    assign grant_vld      = r_grant_vld;
    assign grant_id       = GID_W'(r_grant_id);
    assign m_adr          = r_m_desc.adr;
    assign m_wr_data      = r_m_desc.wr_data;
    assign m_wr_bytes     = r_m_desc.wr_bytes;
    assign m_rd_bytes     = r_m_desc.rd_bytes;
    assign m_rd_channels  = r_m_desc.rd_channels;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_wr_flg, req_rd_flg;
    logic [7*N-1:0] req_adr;
    logic [32*N-1:0] req_wr_data;
    logic [3*N-1:0] req_wr_bytes, req_rd_bytes;
    logic [4*N-1:0] req_rd_channels;
    logic [N-1:0]   req_busy, req_done, req_err, req_rd_data_en;
    logic [2:0]     grant_id;
    logic           grant_vld;
    logic           m_wr_flg, m_rd_flg;
    logic [6:0]     m_adr;
    logic [31:0]    m_wr_data;
    logic [2:0]     m_wr_bytes, m_rd_bytes;
    logic [3:0]     m_rd_channels;
    logic           m_rd_data_en, m_done;

    i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .reset(reset),
        .req_wr_flg(req_wr_flg), .req_rd_flg(req_rd_flg),
        .req_adr(req_adr), .req_wr_data(req_wr_data),
        .req_wr_bytes(req_wr_bytes), .req_rd_bytes(req_rd_bytes),
        .req_rd_channels(req_rd_channels),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .req_rd_data_en(req_rd_data_en),
        .grant_id(grant_id), .grant_vld(grant_vld),
        .m_wr_flg(m_wr_flg), .m_rd_flg(m_rd_flg), .m_adr(m_adr),
        .m_wr_data(m_wr_data), .m_wr_bytes(m_wr_bytes), .m_rd_bytes(m_rd_bytes),
        .m_rd_channels(m_rd_channels),
        .m_rd_data_en(m_rd_data_en), .m_done(m_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [6:0]  adr;
        logic [31:0] data;
        logic [2:0]  wb;
        logic [2:0]  rb;
        logic [3:0]  ch;
    } cmd_t;

    cmd_t exp_cmd[$];
    int   exp_done[$];
    int   exp_err[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   rden_cnt[N];
    bit   auto_en = 1'b1;

    // Scoreboard: every master command, req_done and req_err is popped
    // against what the stimulus pushed.
    always @(negedge clk) begin
        cmd_t o, e;
        int   d;
        if (m_wr_flg || m_rd_flg) begin
            o = {m_rd_flg, m_adr, m_wr_data, m_wr_bytes, m_rd_bytes, m_rd_channels};
            n_total++;
            if (exp_cmd.size() == 0) begin
                $display("FAIL cmd_unexpected: got %h, required no command", o);
            end else begin
                e = exp_cmd.pop_front();
                if (o !== e) $display("FAIL cmd_fields: got %h, required %h", o, e);
                else n_pass++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
                n_total++;
                if (exp_done.size() == 0) begin
                    $display("FAIL done_unexpected: got req_done[%0d], required none", i);
                end else begin
                    d = exp_done.pop_front();
                    if (i != d) $display("FAIL done_owner: got %0d, required %0d", i, d);
                    else n_pass++;
                end
            end
            if (req_err[i]) begin
                n_total++;
                if (exp_err.size() == 0) begin
                    $display("FAIL err_unexpected: got req_err[%0d], required none", i);
                end else begin
                    d = exp_err.pop_front();
                    if (i != d) $display("FAIL err_owner: got %0d, required %0d", i, d);
                    else n_pass++;
                end
            end
            if (req_rd_data_en[i]) rden_cnt[i]++;
        end
    end

    // Master core model: after each command, optional read strobes, then m_done.
    initial begin
        int n;
        m_done = 1'b0;
        m_rd_data_en = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en && (m_wr_flg || m_rd_flg)) begin
                n = m_rd_flg ? int'(m_rd_channels) : 0;
                repeat (2) @(posedge clk);
                for (int k = 0; k < n; k++) begin
                    @(posedge clk); #1 m_rd_data_en = 1'b1;
                    @(posedge clk); #1 m_rd_data_en = 1'b0;
                end
                @(posedge clk); #1 m_done = 1'b1;
                @(posedge clk); #1 m_done = 1'b0;
            end
        end
    end

    function automatic cmd_t mk(input int i, input bit rd);
        mk = {rd, req_adr[7*i +: 7], req_wr_data[32*i +: 32], req_wr_bytes[3*i +: 3],
              req_rd_bytes[3*i +: 3], req_rd_channels[4*i +: 4]};
    endfunction

    task automatic set_desc(input int i, input logic [6:0] adr, input logic [31:0] data,
                            input logic [2:0] wb, input logic [2:0] rb, input logic [3:0] ch);
        req_adr[7*i +: 7]          = adr;
        req_wr_data[32*i +: 32]    = data;
        req_wr_bytes[3*i +: 3]     = wb;
        req_rd_bytes[3*i +: 3]     = rb;
        req_rd_channels[4*i +: 4]  = ch;
    endtask

    // Flags high for exactly one cycle; returns at the start of cycle t+1.
    task automatic pulse(input logic [N-1:0] wm, input logic [N-1:0] rm);
        @(posedge clk); #1;
        req_wr_flg = wm;
        req_rd_flg = rm;
        @(posedge clk); #1;
        req_wr_flg = '0;
        req_rd_flg = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!grant_vld && req_busy == '0 && exp_cmd.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++;
        if (grant_vld !== 1'b0) $display("FAIL reset_grant_vld: got %b, required 0", grant_vld);
        else n_pass++;
        n_total++;
        if (req_busy !== 2'b00) $display("FAIL reset_busy: got %b, required 00", req_busy);
        else n_pass++;
        n_total++;
        if ({m_wr_flg, m_rd_flg} !== 2'b00) $display("FAIL reset_m_flags: got %b, required 00", {m_wr_flg, m_rd_flg});
        else n_pass++;
        n_total++;
        if ({m_adr, m_wr_data, m_rd_channels} !== 43'd0) $display("FAIL reset_m_fields: got %h, required 0", {m_adr, m_wr_data, m_rd_channels});
        else n_pass++;
        n_total++;
        if ({req_done, req_err, grant_id} !== 7'd0) $display("FAIL reset_status: got %b, required 0", {req_done, req_err, grant_id});
        else n_pass++;
    endtask

    task automatic test_single_write();
        bit ok;
        set_desc(0, 7'h35, 32'hA217_0000, 3'd2, 3'd0, 4'd0);
        exp_cmd.push_back(mk(0, 1'b0));
        exp_done.push_back(0);
        pulse(2'b01, 2'b00);
        @(negedge clk);
        n_total++;
        if ({req_busy[0], m_wr_flg} !== 2'b10) $display("FAIL t1_busy_t1: got %b, required 10", {req_busy[0], m_wr_flg});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (m_wr_flg !== 1'b1) $display("FAIL t1_latency_t2: got %b, required 1", m_wr_flg);
        else n_pass++;
        n_total++;
        if ({m_adr, m_wr_data, m_wr_bytes} !== {7'h35, 32'hA217_0000, 3'd2})
            $display("FAIL t1_fields: got %h, required %h", {m_adr, m_wr_data, m_wr_bytes}, {7'h35, 32'hA217_0000, 3'd2});
        else n_pass++;
        n_total++;
        if ({grant_vld, grant_id} !== 4'b1000) $display("FAIL t1_grant: got %b, required 1000", {grant_vld, grant_id});
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL t1_complete: got busy=%b, required idle", req_busy);
        else n_pass++;
    endtask

    task automatic test_wr_rd();
        bit ok;
        rden_cnt[0] = 0;
        rden_cnt[1] = 0;
        set_desc(1, 7'h48, 32'h1234_5678, 3'd1, 3'd2, 4'd11);
        exp_cmd.push_back(mk(1, 1'b0));
        exp_cmd.push_back(mk(1, 1'b1));
        exp_done.push_back(1);
        pulse(2'b10, 2'b10);
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL t2_complete: got busy=%b, required idle", req_busy);
        else n_pass++;
        n_total++;
        if (rden_cnt[1] != 11) $display("FAIL t2_rden_owner: got %0d, required 11", rden_cnt[1]);
        else n_pass++;
        n_total++;
        if (rden_cnt[0] != 0) $display("FAIL t2_rden_other: got %0d, required 0", rden_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        bit ok;
        do_reset();
        set_desc(0, 7'h10, 32'h0000_00A0, 3'd1, 3'd0, 4'd0);
        set_desc(1, 7'h20, 32'h0000_00B0, 3'd1, 3'd0, 4'd0);
        for (int r = 0; r < 2; r++) begin
            exp_cmd.push_back(mk(0, 1'b0));
            exp_cmd.push_back(mk(1, 1'b0));
            exp_done.push_back(0);
            exp_done.push_back(1);
            pulse(2'b11, 2'b00);
            @(negedge clk);
            n_total++;
            if (req_busy !== 2'b11) $display("FAIL t3_both_latched: got %b, required 11", req_busy);
            else n_pass++;
            wait_idle(ok);
            n_total++;
            if (!ok) $display("FAIL t3_complete: got busy=%b, required idle", req_busy);
            else n_pass++;
        end
    endtask

    task automatic test_rr_rotate();
        bit ok;
        exp_cmd.push_back(mk(0, 1'b0));
        exp_done.push_back(0);
        pulse(2'b01, 2'b00);
        wait_idle(ok);
        exp_cmd.push_back(mk(1, 1'b0));
        exp_cmd.push_back(mk(0, 1'b0));
        exp_done.push_back(1);
        exp_done.push_back(0);
        pulse(2'b11, 2'b00);
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL rr_complete: got busy=%b, required idle", req_busy);
        else n_pass++;
    endtask

    task automatic test_busy_err();
        bit ok;
        auto_en = 1'b0;
        set_desc(0, 7'h3C, 32'hDEAD_BEEF, 3'd4, 3'd0, 4'd0);
        exp_cmd.push_back(mk(0, 1'b0));
        exp_done.push_back(0);
        pulse(2'b01, 2'b00);
        repeat (4) @(posedge clk);
        exp_err.push_back(0);
        pulse(2'b01, 2'b01);
        @(negedge clk);
        n_total++;
        if ({req_err[0], req_busy[0]} !== 2'b11) $display("FAIL t4_err_t1: got %b, required 11", {req_err[0], req_busy[0]});
        else n_pass++;
        @(posedge clk); #1 m_done = 1'b1;
        @(posedge clk); #1 m_done = 1'b0;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL t4_complete: got busy=%b, required idle", req_busy);
        else n_pass++;
        auto_en = 1'b1;
    endtask

    task automatic test_release_edge();
        bit ok;
        bit found;
        set_desc(1, 7'h51, 32'h0102_0304, 3'd3, 3'd0, 4'd0);
        exp_cmd.push_back(mk(1, 1'b0));
        exp_done.push_back(1);
        pulse(2'b10, 2'b00);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_done[1]) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL rel_done_seen: got no req_done[1], required one");
        else n_pass++;
        // Flag held for the RELEASE cycle (rejected) and the next (accepted).
        req_wr_flg = 2'b10;
        exp_err.push_back(1);
        exp_cmd.push_back(mk(1, 1'b0));
        exp_done.push_back(1);
        @(posedge clk); #1;
        @(posedge clk); #1 req_wr_flg = 2'b00;
        @(negedge clk);
        n_total++;
        if (req_busy[1] !== 1'b1) $display("FAIL rel_recapture: got %b, required 1", req_busy[1]);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL rel_complete: got busy=%b, required idle", req_busy);
        else n_pass++;
    endtask

    task automatic test_spurious_done();
        @(posedge clk); #1 m_done = 1'b1;
        @(posedge clk); #1 m_done = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({grant_vld, req_busy, m_wr_flg, m_rd_flg} !== 5'd0)
            $display("FAIL spurious_done: got %b, required 00000", {grant_vld, req_busy, m_wr_flg, m_rd_flg});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        auto_en = 1'b0;
        set_desc(0, 7'h55, 32'h0, 3'd0, 3'd1, 4'd3);
        exp_cmd.push_back(mk(0, 1'b1));
        pulse(2'b00, 2'b01);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_rd_flg) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL t5_rd_issue: got no m_rd_flg, required one");
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({grant_vld, req_busy, m_wr_flg, m_rd_flg} !== 5'd0)
            $display("FAIL t5_abort: got %b, required 00000", {grant_vld, req_busy, m_wr_flg, m_rd_flg});
        else n_pass++;
        @(posedge clk); #1 reset = 1'b0;
        auto_en = 1'b1;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit found;
        int cnt;
        auto_en = 1'b0;
        set_desc(1, 7'h66, 32'hCAFE_0000, 3'd2, 3'd1, 4'd1);
        exp_cmd.push_back(mk(1, 1'b0));
        exp_err.push_back(1);
        pulse(2'b10, 2'b10);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_wr_flg) begin
                found = 1'b1;
                break;
            end
        end
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            cnt++;
            if (req_err[1]) break;
        end
        n_total++;
        if (!found || cnt != 101) $display("FAIL t6_timeout_cycle: got %0d, required 101", cnt);
        else n_pass++;
        wait_idle(ok);
        n_total++;
        if (!ok) $display("FAIL t6_idle: got busy=%b, required idle", req_busy);
        else n_pass++;
        auto_en = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        req_wr_flg = '0;
        req_rd_flg = '0;
        req_adr = '0;
        req_wr_data = '0;
        req_wr_bytes = '0;
        req_rd_bytes = '0;
        req_rd_channels = '0;
        test_reset();
        test_single_write();
        test_wr_rd();
        test_same_cycle();
        test_rr_rotate();
        test_busy_err();
        test_release_edge();
        test_spurious_done();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) @(negedge clk);
        n_total++;
        if (exp_cmd.size() != 0) $display("FAIL cmd_leftover: got %0d, required 0", exp_cmd.size());
        else n_pass++;
        n_total++;
        if (exp_done.size() != 0) $display("FAIL done_leftover: got %0d, required 0", exp_done.size());
        else n_pass++;
        n_total++;
        if (exp_err.size() != 0) $display("FAIL err_leftover: got %0d, required 0", exp_err.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
